// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers plus a 3-column window per row,
// registered gradient/edge outputs one cycle after each interior pixel is accepted.
module sobel_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 482,
  parameter int IMG_H  = 482
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode,
  input  logic [DATA_W+3:0] thresh,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol,
  output logic [DATA_W-1:0] gx_out,
  output logic [DATA_W-1:0] gy_out,
  output logic [DATA_W-1:0] mag_out,
  output logic              frame_done,
  output logic              err_extra
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DATA_W + 3;
  localparam int SW = DATA_W + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [SW-1:0] MAX_S    = SW'({DATA_W{1'b1}});

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
    return signed'({3'b000, p});
  endfunction

  function automatic logic [SW-1:0] abs_g(input logic signed [GW-1:0] v);
    logic [GW-1:0] u;
    u = v[GW-1] ? -v : v;
    return {1'b0, u};
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic [SW-1:0] v);
    return (v > MAX_S) ? '1 : v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] thr(input logic [SW-1:0] v, input logic [SW-1:0] t);
    return (v > t) ? '1 : '0;
  endfunction

  logic [DATA_W-1:0] lb_top [IMG_W];
  logic [DATA_W-1:0] lb_mid [IMG_W];
  logic [DATA_W-1:0] t_c, t_l, m_c, m_l, b_c, b_l;
  logic [CW-1:0]     col, eff_c;
  logic [RW-1:0]     row, eff_r;
  logic              frame_open, mode_q, err_q;
  logic [SW-1:0]     thresh_q;

  logic              accept, last, mode_eff;
  logic [SW-1:0]     thr_eff, ax, ay, s;
  logic [DATA_W-1:0] t_r, m_r, b_r, gx_res, gy_res, mag_res;
  logic signed [GW-1:0] gx, gy;

  logic              vld_p1, sof_p1, eol_p1, done_p1;
  logic [DATA_W-1:0] gx_p1, gy_p1, mag_p1;

  always_comb begin
    accept   = in_valid & (sof | frame_open);
    eff_c    = sof ? '0 : col;
    eff_r    = sof ? '0 : row;
    last     = (eff_r == ROW_LAST) && (eff_c == COL_LAST);
    mode_eff = sof ? mode : mode_q;
    thr_eff  = sof ? thresh : thresh_q;
    t_r      = lb_top[eff_c];
    m_r      = lb_mid[eff_c];
    b_r      = in_data;
    gx = (ext(t_r) + (ext(m_r) <<< 1) + ext(b_r)) - (ext(t_l) + (ext(m_l) <<< 1) + ext(b_l));
    gy = (ext(t_l) + (ext(t_c) <<< 1) + ext(t_r)) - (ext(b_l) + (ext(b_c) <<< 1) + ext(b_r));
    ax = abs_g(gx);
    ay = abs_g(gy);
    s  = ax + ay;
    gx_res  = mode_eff ? sat(ax) : thr(ax, thr_eff);
    gy_res  = mode_eff ? sat(ay) : thr(ay, thr_eff);
    mag_res = mode_eff ? sat(s)  : thr(s, thr_eff);
  end

  // Stage p0: line buffers and column windows advance only on accepted pixels; never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[eff_c] <= m_r;
      lb_mid[eff_c] <= in_data;
      t_l <= t_c;  t_c <= t_r;
      m_l <= m_c;  m_c <= m_r;
      b_l <= b_c;  b_c <= b_r;
    end
  end

  // Stage p1: frame tracking and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_open <= 1'b0;
      col        <= '0;
      row        <= '0;
      mode_q     <= 1'b0;
      thresh_q   <= '0;
      err_q      <= 1'b0;
      vld_p1     <= 1'b0;
      sof_p1     <= 1'b0;
      eol_p1     <= 1'b0;
      done_p1    <= 1'b0;
      gx_p1      <= '0;
      gy_p1      <= '0;
      mag_p1     <= '0;
    end else begin
      vld_p1  <= 1'b0;
      sof_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (in_valid && !sof && !frame_open) err_q <= 1'b1;
      if (in_valid && sof) begin
        mode_q   <= mode;
        thresh_q <= thresh;
      end
      if (accept) begin
        frame_open <= !last;
        if (eff_c == COL_LAST) begin
          col <= '0;
          row <= last ? '0 : eff_r + 1'b1;
        end else begin
          col <= eff_c + 1'b1;
          row <= eff_r;
        end
        if (eff_r >= RW'(2) && eff_c >= CW'(2)) begin
          vld_p1  <= 1'b1;
          sof_p1  <= (eff_r == RW'(2)) && (eff_c == CW'(2));
          eol_p1  <= (eff_c == COL_LAST);
          done_p1 <= last;
          gx_p1   <= gx_res;
          gy_p1   <= gy_res;
          mag_p1  <= mag_res;
        end
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_sof    = sof_p1;
  assign out_eol    = eol_p1;
  assign frame_done = done_p1;
  assign gx_out     = gx_p1;
  assign gy_out     = gy_p1;
  assign mag_out    = mag_p1;
  assign err_extra  = err_q;

endmodule
